// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch tracking queue feeding predictor commit inputs
// Entries allocate at tail, resolve by tag, retire from head; a head mispredict flushes the queue.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_predict,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic             commit_en,
  output logic             branch_commit,
  output logic [31:0]      pc_head,
  output logic             direct_resolved,
  output logic             direct_mispredict,
  output logic             flush,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0] L_FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_resolved;
  logic [DEPTH-1:0] r_predict;
  logic [DEPTH-1:0] r_taken;
  logic [31:0]      r_pc [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             w_nonempty;
  logic             w_commit;
  logic             w_mispredict;
  logic             w_alloc_fire;
  logic             w_res_fire;
  logic [TAG_W-1:0] w_head_inc;
  logic [TAG_W:0]   w_count_next;

  assign w_nonempty   = (r_count != '0);
  assign w_commit     = w_nonempty && r_resolved[r_head] && commit_en;
  assign w_mispredict = w_commit && (r_taken[r_head] != r_predict[r_head]);
  assign w_alloc_fire = alloc_valid && alloc_ready;
  assign w_res_fire   = res_valid && r_valid[res_tag] && !r_resolved[res_tag];
  assign w_head_inc   = r_head + 1'b1;

  assign alloc_ready       = (r_count < L_FULL) && !w_mispredict;
  assign alloc_tag         = r_tail;
  assign branch_commit     = w_commit;
  assign direct_mispredict = w_mispredict;
  assign flush             = w_mispredict;
  assign count             = r_count;
  assign pc_head           = w_nonempty ? r_pc[r_head] : 32'd0;
  assign direct_resolved   = w_nonempty ? r_taken[r_head] : 1'b0;

  always_comb begin
    w_count_next = r_count;
    case ({w_alloc_fire, w_commit})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Commit only touches head and allocate only touches tail; they never alias when both fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_resolved <= '0;
    end else if (w_mispredict) begin
      r_valid    <= '0;
      r_resolved <= '0;
      r_head     <= w_head_inc;
      r_tail     <= w_head_inc;
      r_count    <= '0;
    end else begin
      if (w_res_fire) begin
        r_resolved[res_tag] <= 1'b1;
        r_taken[res_tag]    <= res_taken;
      end
      if (w_commit) begin
        r_valid[r_head]    <= 1'b0;
        r_resolved[r_head] <= 1'b0;
        r_head             <= w_head_inc;
      end
      if (w_alloc_fire) begin
        r_valid[r_tail]    <= 1'b1;
        r_resolved[r_tail] <= 1'b0;
        r_pc[r_tail]       <= alloc_pc;
        r_predict[r_tail]  <= alloc_predict;
        r_tail             <= r_tail + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - scoreboard bench for branch_resolve_queue
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_valid = 1'b0;
  logic [31:0]      alloc_pc = '0;
  logic             alloc_predict = 1'b0;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid = 1'b0;
  logic [TAG_W-1:0] res_tag = '0;
  logic             res_taken = 1'b0;
  logic             commit_en = 1'b0;
  logic             branch_commit;
  logic [31:0]      pc_head;
  logic             direct_resolved;
  logic             direct_mispredict;
  logic             flush;
  logic [TAG_W:0]   count;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_predict(alloc_predict),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .commit_en(commit_en), .branch_commit(branch_commit), .pc_head(pc_head),
    .direct_resolved(direct_resolved), .direct_mispredict(direct_mispredict),
    .flush(flush), .count(count)
  );

  typedef struct { int tag; logic [31:0] pc; bit pred; bit res; bit tk; } ent_t;
  typedef struct { int cnt; bit ready; int tag; bit commit; bit misp; } st_t;
  typedef struct { logic [31:0] pc; bit tk; } cm_t;

  ent_t mq[$];
  st_t  sq[$];
  cm_t  cq[$];
  int   m_tail = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of live branches; tags follow a modulo-DEPTH allocation counter.
  task automatic cycle(input bit av, input logic [31:0] pc, input bit pred,
                       input bit rv, input int rtag, input bit rtk,
                       input bit cen, input bit rs);
    st_t  s;
    cm_t  c;
    ent_t e;
    int   n;
    bit   cm, mp;
    @(negedge clk);
    rst = rs; alloc_valid = av; alloc_pc = pc; alloc_predict = pred;
    res_valid = rv; res_tag = TAG_W'(rtag); res_taken = rtk; commit_en = cen;
    n  = mq.size();
    cm = (n > 0) && mq[0].res && cen;
    mp = cm && (mq[0].tk != mq[0].pred);
    s.cnt = n; s.ready = (n < DEPTH) && !mp; s.tag = m_tail; s.commit = cm; s.misp = mp;
    sq.push_back(s);
    if (cm) begin
      c.pc = mq[0].pc; c.tk = mq[0].tk;
      cq.push_back(c);
    end
    if (rs) begin
      mq.delete();
      m_tail = 0;
    end else if (mp) begin
      m_tail = (mq[0].tag + 1) % DEPTH;
      mq.delete();
    end else begin
      if (rv)
        foreach (mq[i])
          if (mq[i].tag == rtag && !mq[i].res) begin
            mq[i].res = 1'b1;
            mq[i].tk  = rtk;
          end
      if (cm) void'(mq.pop_front());
      if (av && s.ready) begin
        e.tag = m_tail; e.pc = pc; e.pred = pred; e.res = 1'b0; e.tk = 1'b0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  task automatic idle(input bit cen);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 0, 1'b0, cen, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && mq.size() > 0; k++) begin
      if (!mq[0].res) cycle(1'b0, 32'd0, 1'b0, 1'b1, mq[0].tag, mq[0].pred, 1'b1, 1'b0);
      else            idle(1'b1);
    end
  endtask

  initial begin : monitor
    st_t s;
    cm_t c;
    forever begin
      @(negedge clk);
      #1;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("count", 32'(count), s.cnt);
        chk("alloc_ready", 32'(alloc_ready), 32'(s.ready));
        chk("alloc_tag", 32'(alloc_tag), s.tag);
        chk("branch_commit", 32'(branch_commit), 32'(s.commit));
        chk("direct_mispredict", 32'(direct_mispredict), 32'(s.misp));
        chk("flush", 32'(flush), 32'(s.misp));
        if (s.cnt == 0) begin
          chk("pc_head_empty", pc_head, 32'd0);
          chk("resolved_empty", 32'(direct_resolved), 32'd0);
        end
        if (branch_commit) begin
          if (cq.size() == 0) begin
            total++; bad++;
            $display("FAIL commit_unexpected: got pc 0x%0h want no commit", pc_head);
          end else begin
            c = cq.pop_front();
            chk("commit_pc", pc_head, c.pc);
            chk("commit_taken", 32'(direct_resolved), 32'(c.tk));
          end
        end
      end
    end
  end

  initial begin : stim
    int t[4];
    int r, pick;
    bit pr;
    // reset then a single branch
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);
    // fill, overflow attempt, retire one
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h300 + 4*i, i[0], 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, mq[0].tag, mq[0].pred, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    drain();
    // out-of-order resolve, in-order commit
    for (int i = 0; i < 3; i++) begin
      t[i] = m_tail;
      cycle(1'b1, 32'h200 + 4*i, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 2; i >= 0; i--) cycle(1'b0, 32'd0, 1'b0, 1'b1, t[i], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    // mispredict flush, then resolve to a flushed tag
    for (int i = 0; i < 4; i++) begin
      t[i] = m_tail;
      cycle(1'b1, 32'h400 + 4*i, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1, t[0], 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h4ff, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, t[1], 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    cycle(1'b1, 32'h500, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    drain();
    // wrap-around
    for (int i = 0; i < 20; i++) begin
      t[0] = m_tail;
      cycle(1'b1, 32'h1000 + 16*i, i[0], 1'b0, 0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'd0, 1'b0, 1'b1, t[0], i[0], 1'b1, 1'b0);
      idle(1'b1);
    end
    // stall then mid-stream reset
    cycle(1'b1, 32'h600, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, mq[0].tag, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h700 + 4*i, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, mq[0].tag, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h7f0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      pick = $urandom_range(0, 7);
      pr = 1'b0;
      if (mq.size() > 0 && r < 75) begin
        pick = mq[$urandom_range(0, mq.size() - 1)].tag;
        foreach (mq[k]) if (mq[k].tag == pick) pr = mq[k].pred;
        if ($urandom_range(0, 99) < 15) pr = !pr;
      end else begin
        pr = $urandom_range(0, 1);
      end
      cycle($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 99) < 60, pick, pr,
            $urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 70 : 20),
            $urandom_range(0, 299) == 0);
    end
    drain();
    idle(1'b0);
    repeat (2) @(negedge clk);
    #3;
    chk("status_queue_drained", sq.size(), 32'd0);
    chk("commit_queue_drained", cq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order tracking queue for conditional branches that are in flight between fetch-time prediction and commit.
- Fetch allocates an entry per predicted branch. Execute writes the resolved direction by tag. Entries retire oldest-first when the commit stage permits.
- Generates the commit-side inputs of the direction predictor: branch_commit, pc_head, direct_resolved and direct_mispredict.
- On a head mispredict it flushes all younger, wrong-path entries.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2, at least 2.
- TAG_W, 3, entry tag width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- alloc_valid  input  1  fetch presents a predicted branch.
- alloc_pc  input  32  PC of the allocating branch.
- alloc_predict  input  1  predicted direction; 1 = taken.
- alloc_ready  output  1  queue accepts an allocation this cycle.
- alloc_tag  output  TAG_W  tag assigned to the allocation; equals the tail pointer.
- res_valid  input  1  execute resolves a branch.
- res_tag  input  TAG_W  tag of the resolving branch.
- res_taken  input  1  actual direction.
- commit_en  input  1  commit stage permits a branch retire this cycle.
- branch_commit  output  1  head retires this cycle.
- pc_head  output  32  PC of the head entry.
- direct_resolved  output  1  actual direction of the head entry.
- direct_mispredict  output  1  head retires with actual direction different from predicted.
- flush  output  1  equals direct_mispredict; all younger entries are discarded.
- count  output  TAG_W+1  number of valid entries.

Behaviour:
- Storage per entry: valid, resolved, pc[31:0], predict, taken. Pointers head and tail are TAG_W wide and wrap modulo DEPTH. count is TAG_W+1 wide.
- Reset (rst=1 at a clock edge): head=0, tail=0, count=0, all valid and resolved bits cleared.
- Outputs during and after reset: alloc_ready=1, alloc_tag=0, branch_commit=0, direct_mispredict=0, flush=0, count=0, pc_head=0, direct_resolved=0.
- Reset has priority over every other input. A reset in mid-operation discards all entries.
- All outputs are combinational functions of registered state plus commit_en. There is no combinational path from alloc_* or res_* to any output.
- alloc_ready = (count < DEPTH) && !direct_mispredict.
  - There is no same-cycle bypass: when the queue is full, alloc_ready=0 even if a commit occurs that cycle.
- Allocate fires when alloc_valid && alloc_ready:
  - entry[tail] is written with valid=1, resolved=0, pc=alloc_pc, predict=alloc_predict;
  - tail increments.
- Allocation is latency 1: the entry is visible as head no earlier than the next cycle.
- Resolve fires when res_valid && entry[res_tag].valid && !entry[res_tag].resolved:
  - set resolved=1 and taken=res_taken.
  - A resolve to an invalid entry is ignored.
  - A resolve to an already-resolved entry is ignored; the first resolve wins.
- A resolve is visible to commit in the next cycle. A resolve and a commit-check on the head in the same cycle do not commit that cycle.
- pc_head = entry[head].pc, and direct_resolved = entry[head].taken. Both outputs are 0 when count=0.
- branch_commit = (count != 0) && entry[head].resolved && commit_en.
- direct_mispredict = branch_commit && (entry[head].taken != entry[head].predict).
- Normal commit (branch_commit=1, direct_mispredict=0):
  - clear entry[head].valid and entry[head].resolved;
  - head increments;
  - count decrements, or is unchanged if an allocate also fires.
- Mispredict commit (direct_mispredict=1):
  - clear valid and resolved on all entries;
  - head and tail both become old head+1;
  - count becomes 0.
  - Any resolve arriving in the same cycle is dropped.
- Simultaneous allocate and normal commit: both take effect and count is unchanged.
- Wrap-around: tail wraps from DEPTH-1 to 0; ordering is preserved across the wrap.
- Only the head retires; at most one retire per cycle. Out-of-order resolves are held until the entry reaches head.

Test Plan:
- Reset, then one branch: allocate pc=0x100, predict=1 -> alloc_tag=0, count=1. Resolve tag0 taken=1, commit_en=1 -> next cycle branch_commit=1, pc_head=0x100, direct_resolved=1, direct_mispredict=0; then count=0.
- Fill: 8 allocates with no commit -> count=8, alloc_ready=0. A 9th alloc_valid is not accepted and tail is unchanged. Retire one -> alloc_ready=1 on the following cycle.
- Out-of-order resolve: allocate pcs 0x200, 0x204, 0x208; resolve tag2 then tag1 then tag0 -> commits occur in order 0x200, 0x204, 0x208, one per cycle, with commit_en held high.
- Mispredict flush: 4 entries; head predict=0 resolved taken=1 -> direct_mispredict=1, flush=1, alloc_ready=0 that cycle. Next cycle count=0, tail=head=old head+1. A later resolve to a flushed tag is ignored.
- Wrap-around: run 20 allocate/commit pairs -> tags cycle 0..7,0..; pc_head always matches the oldest allocated pc.
- Stall and reset: head resolved with commit_en=0 for 3 cycles -> no commit, outputs stable. Assert rst mid-stream with 5 entries -> next cycle count=0, branch_commit=0, alloc_tag=0.
